exec_alu: RTL and testbench

EXEC_ALU -- requirements
Module: exec_alu

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_mul.sv | 59 +++++
 rtl/exec_alu.sv | 128 ++++++++++++
 tb/tb_exec_alu.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the exec_alu slice: opcodes, instruction classes,
// FSM state encoding and flag bit positions.
package exec_pkg;

  localparam logic [1:0] IDEN_ALU = 2'b01;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'b0000,
    OP_ADD   = 4'b0001,
    OP_SUB   = 4'b0010,
    OP_SHL   = 4'b0011,
    OP_SHR   = 4'b0100,
    OP_MUL   = 4'b0101,
    OP_MOVR  = 4'b0110,
    OP_STORE = 4'b1111
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done/product/overflow are valid combinationally during the final iteration.
module exec_mul
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == CNT_W'(DATA_W - 1)) busy <= 1'b0;
    end
  end

  // Final product is taken from acc_next so the result lands on the edge BUSY falls.
  assign done     = busy && (cnt == CNT_W'(DATA_W - 1));
  assign product  = acc_next[DATA_W-1:0];
  assign overflow = |acc_next[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/exec_alu.sv
// Single-issue execute unit with accumulator AR and registered RESULT/FLAGS.
// Optional iterative multiplier compiled in only with EXEC_ALU_MUL_EN defined.
module exec_alu
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        IDEN,
  input  logic [3:0]        OPCODE,
  input  logic [DATA_W-1:0] OPERAND,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT,
  output logic [2:0]        FLAGS,
  output logic [ADDR_W-1:0] STORE_ADDR,
  output logic              STORE_VALID,
  output logic              ERR
);

  logic [DATA_W-1:0] ar, ar_n, res_n, r;
  logic [2:0]        flags_n;
  logic [ADDR_W-1:0] sa_n;
  logic              done_n, sv_n, err_n, c, upd;

`ifdef EXEC_ALU_MUL_EN
  state_e            state, state_n;
  logic              mul_go, mul_done, mul_ovf;
  logic [DATA_W-1:0] mul_prod;

  exec_mul #(.DATA_W(DATA_W)) u_mul (
    .clk      (CLK),
    .rst      (RST),
    .start    (mul_go),
    .a        (ar),
    .b        (OPERAND),
    .busy     (BUSY),
    .done     (mul_done),
    .product  (mul_prod),
    .overflow (mul_ovf)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end
`else
  assign BUSY = 1'b0;
`endif

  always_comb begin
    ar_n    = ar;
    res_n   = RESULT;
    flags_n = FLAGS;
    sa_n    = STORE_ADDR;
    done_n  = 1'b0;
    sv_n    = 1'b0;
    err_n   = 1'b0;
    r       = '0;
    c       = 1'b0;
    upd     = 1'b0;
`ifdef EXEC_ALU_MUL_EN
    state_n = state;
    mul_go  = 1'b0;
    // START is deliberately not examined while the multiplier runs.
    if (state == ST_MUL) begin
      if (mul_done) begin
        state_n = ST_IDLE;
        r       = mul_prod;
        c       = mul_ovf;
        upd     = 1'b1;
        done_n  = 1'b1;
      end
    end else
`endif
    if (START) begin
      done_n = 1'b1;
      if (IDEN == IDEN_ALU) begin
        case (OPCODE)
          OP_LOAD:  ar_n = OPERAND;
          OP_ADD:   begin {c, r} = {1'b0, ar} + {1'b0, OPERAND}; upd = 1'b1; end
          OP_SUB:   begin {c, r} = {1'b0, ar} - {1'b0, OPERAND}; upd = 1'b1; end
          OP_SHL:   begin c = ar[DATA_W-1]; r = ar << 1; upd = 1'b1; end
          OP_SHR:   begin c = ar[0];        r = ar >> 1; upd = 1'b1; end
`ifdef EXEC_ALU_MUL_EN
          OP_MUL:   begin state_n = ST_MUL; mul_go = 1'b1; done_n = 1'b0; end
`endif
          OP_MOVR:  ar_n = RESULT;
          OP_STORE: begin sa_n = RESULT[ADDR_W-1:0]; sv_n = 1'b1; end
          default:  begin r = '0; c = 1'b0; upd = 1'b1; err_n = 1'b1; end
        endcase
      end else begin
        r   = OPERAND;
        upd = 1'b1;
      end
    end
    if (upd) begin
      res_n           = r;
      flags_n[FLAG_N] = r[DATA_W-1];
      flags_n[FLAG_C] = c;
      flags_n[FLAG_Z] = (r == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ar          <= '0;
      RESULT      <= '0;
      FLAGS       <= '0;
      STORE_ADDR  <= '0;
      DONE        <= 1'b0;
      STORE_VALID <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      ar          <= ar_n;
      RESULT      <= res_n;
      FLAGS       <= flags_n;
      STORE_ADDR  <= sa_n;
      DONE        <= done_n;
      STORE_VALID <= sv_n;
      ERR         <= err_n;
    end
  end

endmodule

// File: tb/tb_exec_alu.sv
// Scoreboard bench for exec_alu: commands push expected completions, a monitor
// pops and compares on every DONE. Covers both EXEC_ALU_MUL_EN builds.
module tb_exec_alu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [1:0]  IDEN = 2'b00;
  logic [3:0]  OPCODE = 4'h0;
  logic [15:0] OPERAND = 16'h0;
  logic        BUSY, DONE, STORE_VALID, ERR;
  logic [15:0] RESULT, STORE_ADDR;
  logic [2:0]  FLAGS;

  exec_alu #(.DATA_W(16), .ADDR_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IDEN(IDEN), .OPCODE(OPCODE),
    .OPERAND(OPERAND), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .FLAGS(FLAGS), .STORE_ADDR(STORE_ADDR), .STORE_VALID(STORE_VALID), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned cyc;
    logic [15:0] res;
    logic [2:0]  flags;
    logic [15:0] sa;
    logic        sv;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned passed = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    else passed++;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (DONE === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("done_cycle",  cyc,         e.cyc);
        check("result",      RESULT,      e.res);
        check("flags",       FLAGS,       e.flags);
        check("store_addr",  STORE_ADDR,  e.sa);
        check("store_valid", STORE_VALID, e.sv);
        check("err",         ERR,         e.err);
      end
    end else if (STORE_VALID !== 1'b0 || ERR !== 1'b0) begin
      check("stray_pulse", {30'd0, STORE_VALID, ERR}, 32'd0);
    end
  end

  task automatic issue(input logic [1:0] iden, input logic [3:0] op, input logic [15:0] opnd,
                       input logic [15:0] res, input logic [2:0] fl, input logic [15:0] sa,
                       input logic sv, input logic er, input int unsigned lat);
    exp_t e;
    @(negedge CLK);
    IDEN = iden; OPCODE = op; OPERAND = opnd; START = 1'b1;
    e.cyc = cyc + lat; e.res = res; e.flags = fl; e.sa = sa; e.sv = sv; e.err = er;
    q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Counts BUSY cycles from the negedge after the START edge; optionally
  // injects a LOAD 0xFFFF in the fourth busy cycle, which must be ignored.
  task automatic busy_wait(input bit poke, output int unsigned cnt);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (BUSY !== 1'b1) break;
      cnt++;
      if (poke && n == 3) begin
        IDEN = 2'b01; OPCODE = 4'h0; OPERAND = 16'hFFFF; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  int unsigned bcnt;

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check("rst_result", RESULT, 16'h0);
    check("rst_flags",  FLAGS, 3'b000);
    check("rst_sa",     STORE_ADDR, 16'h0);
    check("rst_pulses", {BUSY, DONE, STORE_VALID, ERR}, 4'b0000);

    //     iden   op    operand   result    flags   sa        sv    err  lat
    issue(2'b01, 4'h0, 16'h0005, 16'h0000, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // LOAD
    issue(2'b01, 4'h1, 16'h0003, 16'h0008, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // ADD
    issue(2'b01, 4'h0, 16'h0003, 16'h0008, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // LOAD
    issue(2'b01, 4'h2, 16'h0005, 16'hFFFE, 3'b110, 16'h0000, 1'b0, 1'b0, 1); // SUB borrow
    issue(2'b01, 4'h0, 16'h8000, 16'hFFFE, 3'b110, 16'h0000, 1'b0, 1'b0, 1); // LOAD
    issue(2'b01, 4'h3, 16'h0000, 16'h0000, 3'b011, 16'h0000, 1'b0, 1'b0, 1); // SHL out
    issue(2'b01, 4'h4, 16'h0000, 16'h4000, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // SHR
    issue(2'b01, 4'h0, 16'h0003, 16'h4000, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // LOAD
    issue(2'b01, 4'h4, 16'h0000, 16'h0001, 3'b010, 16'h0000, 1'b0, 1'b0, 1); // SHR carry
    issue(2'b01, 4'h0, 16'hFFFF, 16'h0001, 3'b010, 16'h0000, 1'b0, 1'b0, 1); // LOAD
    issue(2'b01, 4'h1, 16'h0001, 16'h0000, 3'b011, 16'h0000, 1'b0, 1'b0, 1); // ADD wrap
    issue(2'b10, 4'h0, 16'h1234, 16'h1234, 3'b000, 16'h0000, 1'b0, 1'b0, 1); // pass
    issue(2'b01, 4'hF, 16'h0000, 16'h1234, 3'b000, 16'h1234, 1'b1, 1'b0, 1); // STORE
    issue(2'b01, 4'h6, 16'h0000, 16'h1234, 3'b000, 16'h1234, 1'b0, 1'b0, 1); // MOVR
    issue(2'b01, 4'h1, 16'h0001, 16'h1235, 3'b000, 16'h1234, 1'b0, 1'b0, 1); // ADD
    issue(2'b01, 4'h7, 16'h0055, 16'h0000, 3'b001, 16'h1234, 1'b0, 1'b1, 1); // illegal
    issue(2'b11, 4'hF, 16'h0000, 16'h0000, 3'b001, 16'h1234, 1'b0, 1'b0, 1); // pass, no store
    issue(2'b01, 4'h0, 16'h0100, 16'h0000, 3'b001, 16'h1234, 1'b0, 1'b0, 1); // LOAD
`ifdef EXEC_ALU_MUL_EN
    issue(2'b01, 4'h5, 16'h0300, 16'h0000, 3'b011, 16'h1234, 1'b0, 1'b0, 17); // MUL ovf
    busy_wait(1'b1, bcnt);
    check("mul_busy_cycles", bcnt, 32'd16);
`else
    issue(2'b01, 4'h5, 16'h0300, 16'h0000, 3'b001, 16'h1234, 1'b0, 1'b1, 1); // MUL illegal
    busy_wait(1'b1, bcnt);
    check("busy_never_high", bcnt, 32'd0);
`endif
    issue(2'b01, 4'h1, 16'h0000, 16'h0100, 3'b000, 16'h1234, 1'b0, 1'b0, 1); // AR intact
`ifdef EXEC_ALU_MUL_EN
    issue(2'b01, 4'h0, 16'h0007, 16'h0100, 3'b000, 16'h1234, 1'b0, 1'b0, 1);
    issue(2'b01, 4'h5, 16'h0009, 16'h003F, 3'b000, 16'h1234, 1'b0, 1'b0, 17);
    busy_wait(1'b0, bcnt);
    issue(2'b01, 4'h0, 16'h00FF, 16'h003F, 3'b000, 16'h1234, 1'b0, 1'b0, 1);
    issue(2'b01, 4'h5, 16'h0101, 16'hFFFF, 3'b100, 16'h1234, 1'b0, 1'b0, 17);
    busy_wait(1'b0, bcnt);
    // Abort a MUL in its fifth busy cycle; no completion may follow.
    @(negedge CLK);
    IDEN = 2'b01; OPCODE = 4'h5; OPERAND = 16'h0003; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    check("busy_before_rst", BUSY, 1'b1);
`endif
    RST = 1'b1; START = 1'b1; IDEN = 2'b10; OPERAND = 16'h5555;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    check("abort_busy",   BUSY, 1'b0);
    check("abort_result", RESULT, 16'h0000);
    check("abort_done",   DONE, 1'b0);
    check("abort_state",  {FLAGS, STORE_ADDR}, 19'h0);
    repeat (20) @(negedge CLK);

    issue(2'b10, 4'h0, 16'hBEEF, 16'hBEEF, 3'b100, 16'h0000, 1'b0, 1'b0, 1); // pass
    issue(2'b01, 4'h1, 16'h0000, 16'h0000, 3'b001, 16'h0000, 1'b0, 1'b0, 1); // AR reset

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    check("pending_expectations", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
